// File: rtl/sgmii_pkg.sv
// rtl/sgmii_pkg.sv - shared 8b/10b code constants and TBI bit-order helper
package sgmii_pkg;

    localparam logic [7:0] K28_5 = 8'hBC;
    localparam logic [7:0] K23_7 = 8'hF7;
    localparam logic [7:0] K27_7 = 8'hFB;
    localparam logic [7:0] K29_7 = 8'hFD;
    localparam logic [7:0] K30_7 = 8'hFE;

    localparam logic [7:0] D21_5 = 8'hB5;
    localparam logic [7:0] D2_2  = 8'h42;
    localparam logic [7:0] D5_6  = 8'hC5;
    localparam logic [7:0] D16_2 = 8'h50;

    // Internal code groups keep bit a at [9] so literals read as abcdei fghj.
    localparam logic [9:0] K28_5_RDN = 10'b0011111010;
    localparam logic [9:0] K28_5_RDP = 10'b1100000101;

    function automatic logic [9:0] order_bits(input logic [9:0] code, input int bit_order);
        logic [9:0] r;
        for (int i = 0; i < 10; i++) begin
            r[i] = (bit_order == 0) ? code[9-i] : code[i];
        end
        return r;
    endfunction

endpackage

// File: rtl/sgmii_8b10b_lut.sv
// rtl/sgmii_8b10b_lut.sv - combinational Clause 36 8b/10b code group and RD lookup
module sgmii_8b10b_lut
    import sgmii_pkg::*;
(
    input  logic [7:0] tx_byte,
    input  logic       is_k,
    input  logic       rd_in,
    output logic [9:0] code10,
    output logic       rd_next,
    output logic       k_illegal
);

    logic [4:0] raw_x;
    logic [2:0] raw_y;
    logic       k_legal;
    logic [7:0] sel_byte;
    logic [4:0] x;
    logic [2:0] y;
    logic [5:0] base6;
    logic [3:0] base4;
    logic       flip6;
    logic       flip4;
    logic       rd6;
    logic       use_a7;
    logic [5:0] sub6;
    logic [3:0] sub4;

    assign raw_x = tx_byte[4:0];
    assign raw_y = tx_byte[7:5];

    always_comb begin
        k_legal = (raw_x == 5'd28) ||
                  ((raw_y == 3'd7) && ((raw_x == 5'd23) || (raw_x == 5'd27) ||
                                       (raw_x == 5'd29) || (raw_x == 5'd30)));
        k_illegal = is_k && !k_legal;
        sel_byte  = k_illegal ? K28_5 : tx_byte;
        x         = sel_byte[4:0];
        y         = sel_byte[7:5];
    end

    // 5b/6b RD- column; the RD+ form is derived by complement below.
    always_comb begin
        base6 = 6'b000000;
        case (x)
            5'd0:  base6 = 6'b100111;
            5'd1:  base6 = 6'b011101;
            5'd2:  base6 = 6'b101101;
            5'd3:  base6 = 6'b110001;
            5'd4:  base6 = 6'b110101;
            5'd5:  base6 = 6'b101001;
            5'd6:  base6 = 6'b011001;
            5'd7:  base6 = 6'b111000;
            5'd8:  base6 = 6'b111001;
            5'd9:  base6 = 6'b100101;
            5'd10: base6 = 6'b010101;
            5'd11: base6 = 6'b110100;
            5'd12: base6 = 6'b001101;
            5'd13: base6 = 6'b101100;
            5'd14: base6 = 6'b011100;
            5'd15: base6 = 6'b010111;
            5'd16: base6 = 6'b011011;
            5'd17: base6 = 6'b100011;
            5'd18: base6 = 6'b010011;
            5'd19: base6 = 6'b110010;
            5'd20: base6 = 6'b001011;
            5'd21: base6 = 6'b101010;
            5'd22: base6 = 6'b011010;
            5'd23: base6 = 6'b111010;
            5'd24: base6 = 6'b110011;
            5'd25: base6 = 6'b100110;
            5'd26: base6 = 6'b010110;
            5'd27: base6 = 6'b110110;
            5'd28: base6 = is_k ? 6'b001111 : 6'b001110;
            5'd29: base6 = 6'b101110;
            5'd30: base6 = 6'b011110;
            5'd31: base6 = 6'b101011;
            default: base6 = 6'b000000;
        endcase
        // D.7 is neutral yet still alternates with RD.
        flip6 = ($countones(base6) != 3) || (x == 5'd7);
        sub6  = (rd_in && flip6) ? ~base6 : base6;
        rd6   = rd_in ^ ($countones(base6) != 3);
    end

    always_comb begin
        use_a7 = is_k ||
                 (!rd6 && ((x == 5'd17) || (x == 5'd18) || (x == 5'd20))) ||
                 ( rd6 && ((x == 5'd11) || (x == 5'd13) || (x == 5'd14)));
        base4 = 4'b0000;
        case (y)
            3'd0: base4 = 4'b1011;
            3'd1: base4 = is_k ? 4'b0110 : 4'b1001;
            3'd2: base4 = is_k ? 4'b1010 : 4'b0101;
            3'd3: base4 = 4'b1100;
            3'd4: base4 = 4'b1101;
            3'd5: base4 = is_k ? 4'b0101 : 4'b1010;
            3'd6: base4 = is_k ? 4'b1001 : 4'b0110;
            3'd7: base4 = use_a7 ? 4'b0111 : 4'b1110;
            default: base4 = 4'b0000;
        endcase
        // Control neutral groups and D.x.3 alternate; other neutral data groups do not.
        flip4 = ($countones(base4) != 2) || (y == 3'd3) ||
                (is_k && ((y == 3'd1) || (y == 3'd2) || (y == 3'd5) || (y == 3'd6)));
        sub4    = (rd6 && flip4) ? ~base4 : base4;
        rd_next = rd6 ^ ($countones(base4) != 2);
        code10  = {sub6, sub4};
    end

endmodule

// File: rtl/sgmii_8b10b_enc.sv
// rtl/sgmii_8b10b_enc.sv - registered 8b/10b encoder with RD state and illegal-K counter
module sgmii_8b10b_enc
    import sgmii_pkg::*;
#(
    parameter logic INIT_RD   = 1'b0,
    parameter int   BIT_ORDER = 0,
    parameter int   ERR_CNT_W = 16
) (
    input  logic                 tbi_tx_clk,
    input  logic                 rst,
    input  logic [7:0]           tx_byte,
    input  logic                 tx_is_k,
    output logic [9:0]           tbi_txd,
    output logic                 rd_out,
    output logic                 tx_k_err,
    output logic [ERR_CNT_W-1:0] k_err_cnt
);

    logic [9:0] code10;
    logic       rd_next;
    logic       k_illegal;

    // rd_out doubles as the running-disparity state register.
    sgmii_8b10b_lut u_lut (
        .tx_byte   (tx_byte),
        .is_k      (tx_is_k),
        .rd_in     (rd_out),
        .code10    (code10),
        .rd_next   (rd_next),
        .k_illegal (k_illegal)
    );

    always_ff @(posedge tbi_tx_clk) begin
        if (rst) begin
            tbi_txd   <= order_bits(INIT_RD ? K28_5_RDP : K28_5_RDN, BIT_ORDER);
            rd_out    <= INIT_RD;
            tx_k_err  <= 1'b0;
            k_err_cnt <= '0;
        end else begin
            tbi_txd  <= order_bits(code10, BIT_ORDER);
            rd_out   <= rd_next;
            tx_k_err <= k_illegal;
            if (k_illegal && (k_err_cnt != '1)) begin
                k_err_cnt <= k_err_cnt + ERR_CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_sgmii_8b10b_enc.sv
// tb/tb_sgmii_8b10b_enc.sv - self-checking bench for sgmii_8b10b_enc against a table model
module tb_sgmii_8b10b_enc;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_byte = 8'h00;
    logic       tx_is_k = 1'b0;

    logic [9:0]  txd_a, txd_b;
    logic        rd_a, rd_b, err_a, err_b;
    logic [15:0] cnt_a;
    logic [3:0]  cnt_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sgmii_8b10b_enc #(.INIT_RD(1'b0), .BIT_ORDER(0), .ERR_CNT_W(16)) u_dut (
        .tbi_tx_clk (clk), .rst (rst), .tx_byte (tx_byte), .tx_is_k (tx_is_k),
        .tbi_txd (txd_a), .rd_out (rd_a), .tx_k_err (err_a), .k_err_cnt (cnt_a));

    sgmii_8b10b_enc #(.INIT_RD(1'b0), .BIT_ORDER(1), .ERR_CNT_W(4)) u_rev (
        .tbi_tx_clk (clk), .rst (rst), .tx_byte (tx_byte), .tx_is_k (tx_is_k),
        .tbi_txd (txd_b), .rd_out (rd_b), .tx_k_err (err_b), .k_err_cnt (cnt_b));

    // Full RD-/RD+ code tables, abcdei and fghj.
    localparam logic [5:0] T6N [32] = '{
        6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001, 6'b011001, 6'b111000,
        6'b111001, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b010111,
        6'b011011, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b111010,
        6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110, 6'b011110, 6'b101011};
    localparam logic [5:0] T6P [32] = '{
        6'b011000, 6'b100010, 6'b010010, 6'b110001, 6'b001010, 6'b101001, 6'b011001, 6'b000111,
        6'b000110, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b101000,
        6'b100100, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b000101,
        6'b001100, 6'b100110, 6'b010110, 6'b001001, 6'b001110, 6'b010001, 6'b100001, 6'b010100};
    localparam logic [3:0] D4N [8] = '{4'b1011, 4'b1001, 4'b0101, 4'b1100, 4'b1101, 4'b1010, 4'b0110, 4'b1110};
    localparam logic [3:0] D4P [8] = '{4'b0100, 4'b1001, 4'b0101, 4'b0011, 4'b0010, 4'b1010, 4'b0110, 4'b0001};
    localparam logic [3:0] K4N [8] = '{4'b1011, 4'b0110, 4'b1010, 4'b1100, 4'b1101, 4'b0101, 4'b1001, 4'b0111};
    localparam logic [3:0] K4P [8] = '{4'b0100, 4'b1001, 4'b0101, 4'b0011, 4'b0010, 4'b1010, 4'b0110, 4'b1000};
    localparam logic [7:0] LEGAL_K [12] = '{8'h1C, 8'h3C, 8'h5C, 8'h7C, 8'h9C, 8'hBC, 8'hDC, 8'hFC,
                                            8'hF7, 8'hFB, 8'hFD, 8'hFE};

    // Returns {illegal, rd_after, abcdei fghj}.
    function automatic logic [11:0] ref_enc(input logic k, input logic [7:0] b, input logic rd);
        int x, y;
        logic ill, r6;
        logic [5:0] c6;
        logic [3:0] c4;
        x = int'(b[4:0]);
        y = int'(b[7:5]);
        ill = k && !(x == 28 || (y == 7 && (x == 23 || x == 27 || x == 29 || x == 30)));
        if (ill) begin
            x = 28;
            y = 5;
        end
        if (k && x == 28) c6 = rd ? 6'b110000 : 6'b001111;
        else              c6 = rd ? T6P[x] : T6N[x];
        r6 = rd ^ ($countones(c6) != 3);
        if (k)
            c4 = r6 ? K4P[y] : K4N[y];
        else if (y == 7 && ((!r6 && (x == 17 || x == 18 || x == 20)) || (r6 && (x == 11 || x == 13 || x == 14))))
            c4 = r6 ? 4'b1000 : 4'b0111;
        else
            c4 = r6 ? D4P[y] : D4N[y];
        return {ill, r6 ^ ($countones(c4) != 2), c6, c4};
    endfunction

    function automatic logic [9:0] rev10(input logic [9:0] c);
        logic [9:0] r;
        for (int i = 0; i < 10; i++) r[i] = c[9-i];
        return r;
    endfunction

    logic [9:0]  m_code;
    logic        m_rd, m_err;
    logic [15:0] m_cnt16;
    logic [3:0]  m_cnt4;
    wire  [11:0] m_next = ref_enc(tx_is_k, tx_byte, m_rd);

    always @(posedge clk) begin
        if (rst) begin
            m_code  <= 10'b0011111010;
            m_rd    <= 1'b0;
            m_err   <= 1'b0;
            m_cnt16 <= '0;
            m_cnt4  <= '0;
        end else begin
            m_code <= m_next[9:0];
            m_rd   <= m_next[10];
            m_err  <= m_next[11];
            if (m_next[11] && m_cnt16 != 16'hFFFF) m_cnt16 <= m_cnt16 + 16'd1;
            if (m_next[11] && m_cnt4 != 4'hF)      m_cnt4  <= m_cnt4 + 4'd1;
        end
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input logic k, input logic [7:0] b, input logic r);
        logic prev_rd;
        int ones;
        prev_rd = rd_a;
        tx_is_k = k;
        tx_byte = b;
        rst     = r;
        @(posedge clk);
        @(negedge clk);
        chk("txd_order0", {6'd0, txd_a}, {6'd0, rev10(m_code)});
        chk("txd_order1", {6'd0, txd_b}, {6'd0, m_code});
        chk("rd_out", {15'd0, rd_a}, {15'd0, m_rd});
        chk("rd_out_rev", {15'd0, rd_b}, {15'd0, m_rd});
        chk("k_err", {14'd0, err_a, err_b}, {14'd0, m_err, m_err});
        chk("k_err_cnt16", cnt_a, m_cnt16);
        chk("k_err_cnt4", {12'd0, cnt_b}, {12'd0, m_cnt4});
        ones = $countones(txd_a);
        chk("ones_in_456", {15'd0, (ones >= 4 && ones <= 6)}, 16'd1);
        if (!r) chk("rd_parity", {15'd0, rd_a}, {15'd0, prev_rd ^ (ones != 5)});
    endtask

    task automatic lit(input string name, input logic [9:0] want, input logic want_rd);
        chk(name, {6'd0, txd_b}, {6'd0, want});
        chk(name, {6'd0, txd_a}, {6'd0, rev10(want)});
        chk(name, {15'd0, rd_a}, {15'd0, want_rd});
    endtask

    initial begin
        logic k;
        logic [7:0] b;
        @(negedge clk);
        for (int i = 0; i < 3; i++) tick(1'($urandom_range(0, 1)), 8'($urandom), 1'b1);
        lit("reset_code", 10'b0011111010, 1'b0);
        chk("reset_err", {14'd0, err_a, err_b}, 16'd0);
        chk("reset_cnt", cnt_a, 16'd0);

        for (int i = 0; i < 2; i++) begin
            tick(1'b1, 8'hBC, 1'b0); lit("i2_k28_5", 10'b0011111010, 1'b1);
            tick(1'b0, 8'h50, 1'b0); lit("i2_d16_2", 10'b1001000101, 1'b0);
        end

        tick(1'b1, 8'hBC, 1'b0); lit("i1_k28_5n", 10'b0011111010, 1'b1);
        tick(1'b0, 8'hC5, 1'b0); lit("d5_6", 10'b1010010110, 1'b1);
        tick(1'b1, 8'hBC, 1'b0); lit("k28_5p", 10'b1100000101, 1'b0);
        tick(1'b0, 8'hB5, 1'b0); lit("d21_5", 10'b1010101010, 1'b0);

        tick(1'b0, 8'h00, 1'b0); lit("d0_0n", 10'b1001110100, 1'b0);
        tick(1'b1, 8'hBC, 1'b0);
        tick(1'b0, 8'h00, 1'b0); lit("d0_0p", 10'b0110001011, 1'b1);
        tick(1'b1, 8'hBC, 1'b0);
        tick(1'b0, 8'hF1, 1'b0); lit("d17_7_a7", 10'b1000110111, 1'b1);
        tick(1'b1, 8'hBC, 1'b0);
        tick(1'b0, 8'hE3, 1'b0); lit("d3_7_p7", 10'b1100011110, 1'b1);

        tick(1'b1, 8'hBC, 1'b0);
        tick(1'b1, 8'h00, 1'b0); lit("illegal_k_1", 10'b0011111010, 1'b1);
        chk("illegal_err_1", {14'd0, err_a, err_b}, 16'd3);
        tick(1'b1, 8'h00, 1'b0); lit("illegal_k_2", 10'b1100000101, 1'b0);
        chk("illegal_err_2", {14'd0, err_a, err_b}, 16'd3);
        chk("illegal_cnt_2", cnt_a, 16'd2);
        for (int i = 0; i < 20; i++) tick(1'b1, 8'h00, 1'b0);
        chk("cnt4_saturated", {12'd0, cnt_b}, 16'd15);
        chk("cnt16_count", cnt_a, 16'd22);
        tick(1'b0, 8'h00, 1'b0);
        chk("err_clears", {14'd0, err_a, err_b}, 16'd0);

        for (int i = 0; i < 1500; i++) begin
            if (i == 700) begin
                for (int j = 0; j < 4 && !m_rd; j++) tick(1'b1, 8'hBC, 1'b0);
                chk("pre_rst_rd_plus", {15'd0, rd_a}, 16'd1);
                tick(1'($urandom_range(0, 1)), 8'($urandom), 1'b1);
                lit("midstream_rst", 10'b0011111010, 1'b0);
                chk("midstream_rst_cnt", {cnt_a[3:0], cnt_b}, 8'd0);
            end
            k = ($urandom_range(0, 3) == 0);
            b = (k && $urandom_range(0, 1) == 1) ? LEGAL_K[$urandom_range(0, 11)] : 8'($urandom);
            tick(k, b, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
